// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable-frame UART receiver (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) with an input synchroniser, 3-tap majority vote,
// break detection, and a single-entry valid/ready holding register.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_serial_in in   asynchronous serial line, idle high
//   rx_data_out  out  received word, stable while rx_valid is high
//   rx_valid     out  rx_data_out / parity_err / frame_err are valid
//   rx_ready     in   consumer takes the word when rx_valid && rx_ready
//   parity_err   out  word had a parity mismatch (qualified by rx_valid)
//   frame_err    out  a stop bit was sampled low (qualified by rx_valid)
//   overrun_err  out  one-cycle pulse: a completed frame was dropped
//   break_det    out  one-cycle pulse: an all-zero frame (break) was seen
//   busy         out  receiver is not idle
module uart_rx_cfg #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int BAUD_RATE       = 19200,
    parameter int OVERSAMPLE_RATE = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int   TICK_CNT = CLK_FREQ / BAUD_RATE / OVERSAMPLE_RATE;
    localparam int   MID      = OVERSAMPLE_RATE / 2;
    localparam int   TW       = $clog2(TICK_CNT);
    localparam int   SW       = $clog2(OVERSAMPLE_RATE);
    localparam int   BW       = 4;
    localparam logic ODD      = (PARITY == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [2:0]             vote_q, vote_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_pend_q, par_pend_d;
    logic                   frm_pend_q, frm_pend_d;
    logic                   nz_q, nz_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   brk_q, brk_d;

    logic rxs, tick, vote, last_sample, decide;

    assign rxs         = sync_q[SYNC_STAGES-1];
    assign tick        = (state_q != S_IDLE) && (tick_cnt_q == TW'(TICK_CNT - 1));
    assign vote        = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);
    assign last_sample = (sample_cnt_q == SW'(OVERSAMPLE_RATE - 1));
    // Bit decisions fall one full bit period after the validated start centre.
    assign decide      = tick && last_sample;

    always_comb begin
        state_d      = state_q;
        sync_d       = {sync_q[SYNC_STAGES-2:0], rx_serial_in};
        tick_cnt_d   = tick_cnt_q;
        sample_cnt_d = sample_cnt_q;
        vote_d       = vote_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_pend_d   = par_pend_q;
        frm_pend_d   = frm_pend_q;
        nz_d         = nz_q;
        data_d       = data_q;
        valid_d      = valid_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        ovr_d        = 1'b0;
        brk_d        = 1'b0;

        // Tick counter is parked at 0 while idle so the first tick lands
        // exactly TICK_CNT cycles after start detection.
        if (state_q == S_IDLE || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        if (tick) begin
            vote_d       = {vote_q[1:0], rxs};
            sample_cnt_d = last_sample ? '0 : sample_cnt_q + 1'b1;
        end

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    sample_cnt_d = '0;
                    vote_d       = '0;
                    bit_cnt_d    = '0;
                    par_pend_d   = 1'b0;
                    frm_pend_d   = 1'b0;
                    nz_d         = 1'b0;
                    state_d      = S_START;
                end
            end
            S_START: begin
                if (tick && sample_cnt_q == SW'(MID)) begin
                    if (!vote) begin
                        sample_cnt_d = '0;
                        state_d      = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    nz_d    = nz_q | vote;
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (decide) begin
                    nz_d = nz_q | vote;
                    if (vote != ((^shift_q) ^ ODD)) begin
                        par_pend_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    nz_d = nz_q | vote;
                    if (!vote) begin
                        frm_pend_d = 1'b1;
                    end
                    if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
                        if (!(nz_q || vote)) begin
                            // Every sampled bit was low: a break, not a word.
                            brk_d   = 1'b1;
                            state_d = S_BREAK;
                        end else begin
                            // Leave mid stop bit so a back-to-back start is caught.
                            state_d = S_IDLE;
                            if (!valid_q || rx_ready) begin
                                data_d  = shift_q;
                                perr_d  = par_pend_q;
                                ferr_d  = frm_pend_q | ~vote;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (tick && vote) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync_q       <= '1;
            tick_cnt_q   <= '0;
            sample_cnt_q <= '0;
            vote_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_pend_q   <= 1'b0;
            frm_pend_q   <= 1'b0;
            nz_q         <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            vote_q       <= vote_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_pend_q   <= par_pend_d;
            frm_pend_q   <= frm_pend_d;
            nz_q         <= nz_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
            brk_q        <= brk_d;
        end
    end

    assign rx_data_out = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;
    assign break_det   = brk_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receivers (8N1, 8E1, 7O2) sharing one clock and reset,
// each driven by its own serial line. Frames are built bit by bit from the
// frame rules; expected words and error flags come from a small frame model.
module tb_uart_rx_cfg;

    localparam int CLK_FREQ = 1_228_800;
    localparam int BAUD     = 19200;
    localparam int OSR      = 16;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] line  = 3'b111;
    logic [2:0] ready = 3'b000;
    logic [2:0] valid, perr, ferr, ovr, brk, busy;
    logic [7:0] dout0, dout1;
    logic [6:0] dout2;

    int db [3] = '{8, 8, 7};
    int pm [3] = '{0, 1, 2};
    int sb [3] = '{1, 1, 2};

    int checks = 0;
    int errors = 0;

    // Words accepted through the handshake, as {parity_err, frame_err, data}.
    logic [10:0] cap0[$];
    logic [10:0] cap1[$];
    logic [10:0] cap2[$];
    int rd [3]      = '{0, 0, 0};
    int vcyc [3]    = '{0, 0, 0};
    int ovr_cnt [3] = '{0, 0, 0};
    int brk_cnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE_RATE(OSR),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
        .clk(clk), .rst(rst), .rx_serial_in(line[0]), .rx_data_out(dout0),
        .rx_valid(valid[0]), .rx_ready(ready[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun_err(ovr[0]), .break_det(brk[0]), .busy(busy[0]));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE_RATE(OSR),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
        .clk(clk), .rst(rst), .rx_serial_in(line[1]), .rx_data_out(dout1),
        .rx_valid(valid[1]), .rx_ready(ready[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun_err(ovr[1]), .break_det(brk[1]), .busy(busy[1]));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE_RATE(OSR),
                  .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)) u_7o2 (
        .clk(clk), .rst(rst), .rx_serial_in(line[2]), .rx_data_out(dout2),
        .rx_valid(valid[2]), .rx_ready(ready[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun_err(ovr[2]), .break_det(brk[2]), .busy(busy[2]));

    function automatic logic [10:0] cur_word(input int idx);
        case (idx)
            0:       return {perr[0], ferr[0], 1'b0, dout0};
            1:       return {perr[1], ferr[1], 1'b0, dout1};
            default: return {perr[2], ferr[2], 2'b00, dout2};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid[0] && ready[0]) cap0.push_back(cur_word(0));
            if (valid[1] && ready[1]) cap1.push_back(cur_word(1));
            if (valid[2] && ready[2]) cap2.push_back(cur_word(2));
            for (int i = 0; i < 3; i++) begin
                if (valid[i] === 1'b1) vcyc[i] <= vcyc[i] + 1;
                if (ovr[i] === 1'b1) ovr_cnt[i] <= ovr_cnt[i] + 1;
                if (brk[i] === 1'b1) brk_cnt[i] <= brk_cnt[i] + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    // ---------------- frame model ----------------
    function automatic logic [8:0] mask_data(input int idx, input logic [8:0] d);
        logic [8:0] m;
        m = 9'((1 << db[idx]) - 1);
        return d & m;
    endfunction

    function automatic logic par_bit(input int idx, input logic [8:0] d);
        logic p;
        p = ^mask_data(idx, d);
        return (pm[idx] == 2) ? ~p : p;
    endfunction

    // Expected {parity_err, frame_err, data} for a frame sent with the given
    // parity override (-1 = correct parity) and stop-bit low mask.
    function automatic logic [10:0] model_rx(input int idx, input logic [8:0] d,
                                             input int par_force, input int stop_mask);
        logic pe, fe;
        pe = (pm[idx] != 0) && (par_force >= 0) && (par_force[0] != par_bit(idx, d));
        fe = (stop_mask & ((1 << sb[idx]) - 1)) != 0;
        return {pe, fe, mask_data(idx, d)};
    endfunction

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input int idx, input logic v, input bit spike);
        for (int c = 0; c < BIT_CLKS; c++) begin
            line[idx] = (spike && c >= BIT_CLKS/2 - 2 && c < BIT_CLKS/2 + 2) ? ~v : v;
            step(1);
        end
    endtask

    task automatic send_frame(input int idx, input logic [8:0] d, input int par_force,
                              input int stop_mask, input int spike_bit);
        logic pb;
        drive_bit(idx, 1'b0, 1'b0);
        for (int b = 0; b < db[idx]; b++) drive_bit(idx, d[b], (b == spike_bit));
        if (pm[idx] != 0) begin
            pb = (par_force >= 0) ? par_force[0] : par_bit(idx, d);
            drive_bit(idx, pb, 1'b0);
        end
        for (int s = 0; s < sb[idx]; s++) drive_bit(idx, ~stop_mask[s], 1'b0);
        line[idx] = 1'b1;
    endtask

    task automatic idle(input int idx, input int bits);
        line[idx] = 1'b1;
        step(bits * BIT_CLKS);
    endtask

    task automatic pop_word(input int idx, output bit found, output logic [10:0] w);
        found = 1'b0;
        w     = '0;
        case (idx)
            0: if (cap0.size() > rd[0]) begin w = cap0[rd[0]]; found = 1'b1; end
            1: if (cap1.size() > rd[1]) begin w = cap1[rd[1]]; found = 1'b1; end
            default: if (cap2.size() > rd[2]) begin w = cap2[rd[2]]; found = 1'b1; end
        endcase
        if (found) rd[idx] = rd[idx] + 1;
    endtask

    function automatic int avail(input int idx);
        case (idx)
            0:       return cap0.size() - rd[0];
            1:       return cap1.size() - rd[1];
            default: return cap2.size() - rd[2];
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step(5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cur_word(i), valid[i], ovr[i], brk[i], busy[i]} !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got word=%h valid=%b ovr=%b brk=%b busy=%b expected all 0",
                         i, cur_word(i), valid[i], ovr[i], brk[i], busy[i]);
            end
        end
        rst = 1'b0;
        step(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d got busy=%b valid=%b expected 0 0", i, busy[i], valid[i]);
            end
        end
    endtask

    task automatic test_8n1();
        bit found;
        logic [10:0] w, exp;
        logic [8:0] d;
        int v0;
        ready[0] = 1'b1;
        v0 = vcyc[0];
        send_frame(0, 9'h0A5, -1, 0, -1);
        step(4);
        pop_word(0, found, w);
        checks++;
        if (!found || w !== 11'h0A5) begin
            errors++;
            $display("FAIL 8n1_a5 got found=%0d word=%h expected 0a5", found, w);
        end
        checks++;
        if (vcyc[0] - v0 !== 1) begin
            errors++;
            $display("FAIL 8n1_valid_width got %0d cycles expected 1", vcyc[0] - v0);
        end
        for (int k = 0; k < 6; k++) begin
            d   = 9'($urandom_range(0, 255));
            exp = model_rx(0, d, -1, 0);
            send_frame(0, d, -1, 0, -1);
            idle(0, int'($urandom_range(0, 2)));
            step(4);
            pop_word(0, found, w);
            checks++;
            if (!found || w !== exp) begin
                errors++;
                $display("FAIL 8n1_random_%0d got found=%0d word=%h expected %h", k, found, w, exp);
            end
        end
    endtask

    task automatic test_8e1_parity();
        bit found;
        logic [10:0] w, exp;
        logic [8:0] d;
        int pf;
        ready[1] = 1'b1;
        send_frame(1, 9'h05A, 1, 0, -1);
        idle(1, 1);
        pop_word(1, found, w);
        checks++;
        if (!found || w !== 11'h45A) begin
            errors++;
            $display("FAIL 8e1_5a_bad_parity got found=%0d word=%h expected 45a", found, w);
        end
        send_frame(1, 9'h05B, 1, 0, -1);
        idle(1, 1);
        pop_word(1, found, w);
        checks++;
        if (!found || w !== 11'h05B) begin
            errors++;
            $display("FAIL 8e1_5b_good_parity got found=%0d word=%h expected 05b", found, w);
        end
        for (int k = 0; k < 5; k++) begin
            d   = 9'($urandom_range(0, 255));
            pf  = int'($urandom_range(0, 2)) - 1;
            exp = model_rx(1, d, pf, 0);
            send_frame(1, d, pf, 0, -1);
            idle(1, 1);
            pop_word(1, found, w);
            checks++;
            if (!found || w !== exp) begin
                errors++;
                $display("FAIL 8e1_random_%0d got found=%0d word=%h expected %h", k, found, w, exp);
            end
        end
    endtask

    task automatic test_7o2_framing();
        bit found;
        logic [10:0] w, exp;
        logic [8:0] d;
        int sm;
        ready[2] = 1'b1;
        send_frame(2, 9'h03C, -1, 2, -1);
        idle(2, 2);
        pop_word(2, found, w);
        checks++;
        if (!found || w !== 11'h23C) begin
            errors++;
            $display("FAIL 7o2_3c_frame_err got found=%0d word=%h expected 23c", found, w);
        end
        send_frame(2, 9'h041, -1, 0, -1);
        idle(2, 2);
        pop_word(2, found, w);
        checks++;
        if (!found || w !== 11'h041) begin
            errors++;
            $display("FAIL 7o2_41_clean got found=%0d word=%h expected 041", found, w);
        end
        for (int k = 0; k < 5; k++) begin
            d   = 9'($urandom_range(0, 127));
            sm  = int'($urandom_range(0, 3));
            exp = model_rx(2, d, -1, sm);
            send_frame(2, d, -1, sm, -1);
            idle(2, 2);
            pop_word(2, found, w);
            checks++;
            if (!found || w !== exp) begin
                errors++;
                $display("FAIL 7o2_random_%0d got found=%0d word=%h expected %h", k, found, w, exp);
            end
        end
    endtask

    task automatic test_glitch();
        bit found;
        logic [10:0] w, exp;
        logic [8:0] d;
        int v0, a0;
        ready[0] = 1'b1;
        v0 = vcyc[0];
        a0 = avail(0);
        line[0] = 1'b0;
        step(OSR / 4);
        line[0] = 1'b1;
        step(2);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_detected got busy=%b expected 1", busy[0]);
        end
        step(100);
        checks++;
        if (busy[0] !== 1'b0 || vcyc[0] - v0 !== 0 || avail(0) !== a0) begin
            errors++;
            $display("FAIL glitch_rejected got busy=%b valid_cycles=%0d words=%0d expected 0 0 %0d",
                     busy[0], vcyc[0] - v0, avail(0), a0);
        end
        send_frame(0, 9'h000, -1, 0, 3);
        step(4);
        pop_word(0, found, w);
        checks++;
        if (!found || w !== 11'h000) begin
            errors++;
            $display("FAIL spike_00 got found=%0d word=%h expected 000", found, w);
        end
        for (int k = 0; k < 4; k++) begin
            d   = 9'($urandom_range(0, 255));
            exp = model_rx(1, d, -1, 0);
            send_frame(1, d, -1, 0, int'($urandom_range(0, 7)));
            idle(1, 1);
            pop_word(1, found, w);
            checks++;
            if (!found || w !== exp) begin
                errors++;
                $display("FAIL spike_random_%0d got found=%0d word=%h expected %h", k, found, w, exp);
            end
        end
    endtask

    task automatic test_overrun_break();
        bit found;
        logic [10:0] w;
        int o0, b0, v0;
        ready[0] = 1'b0;
        o0 = ovr_cnt[0];
        send_frame(0, 9'h011, -1, 0, -1);
        idle(0, 1);
        send_frame(0, 9'h022, -1, 0, -1);
        idle(0, 1);
        checks++;
        if (dout0 !== 8'h11 || valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold got data=%h valid=%b expected 11 1", dout0, valid[0]);
        end
        checks++;
        if (ovr_cnt[0] - o0 !== 1 || avail(0) !== 0) begin
            errors++;
            $display("FAIL overrun_pulse got pulses=%0d words=%0d expected 1 0", ovr_cnt[0] - o0, avail(0));
        end
        ready[0] = 1'b1;
        step(3);
        pop_word(0, found, w);
        checks++;
        if (valid[0] !== 1'b0 || !found || w !== 11'h011) begin
            errors++;
            $display("FAIL overrun_drain got valid=%b found=%0d word=%h expected 0 1 011", valid[0], found, w);
        end
        b0 = brk_cnt[0];
        v0 = vcyc[0];
        line[0] = 1'b0;
        step(12 * BIT_CLKS);
        idle(0, 2);
        checks++;
        if (brk_cnt[0] - b0 !== 1 || vcyc[0] - v0 !== 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL break got pulses=%0d valid_cycles=%0d busy=%b expected 1 0 0",
                     brk_cnt[0] - b0, vcyc[0] - v0, busy[0]);
        end
        send_frame(0, 9'h07E, -1, 0, -1);
        step(4);
        pop_word(0, found, w);
        checks++;
        if (!found || w !== 11'h07E) begin
            errors++;
            $display("FAIL after_break_7e got found=%0d word=%h expected 07e", found, w);
        end
    endtask

    task automatic test_reset_mid();
        ready[0] = 1'b1;
        drive_bit(0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) drive_bit(0, 1'b1, 1'b0);
        step(BIT_CLKS / 2);
        rst = 1'b1;
        step(2);
        checks++;
        if ({cur_word(0), valid[0], ovr[0], brk[0], busy[0]} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_frame got word=%h valid=%b busy=%b expected all 0",
                     cur_word(0), valid[0], busy[0]);
        end
        rst = 1'b0;
        idle(0, 12);
        checks++;
        if (avail(0) !== 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard got words=%0d busy=%b expected 0 0", avail(0), busy[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        logic [10:0] w;
        logic [10:0] exp_q[$];
        logic [8:0] d;
        ready[0] = 1'b1;
        send_frame(0, 9'h001, -1, 0, -1);
        send_frame(0, 9'h002, -1, 0, -1);
        idle(0, 1);
        pop_word(0, found, w);
        checks++;
        if (!found || w !== 11'h001) begin
            errors++;
            $display("FAIL b2b_first got found=%0d word=%h expected 001", found, w);
        end
        pop_word(0, found, w);
        checks++;
        if (!found || w !== 11'h002) begin
            errors++;
            $display("FAIL b2b_second got found=%0d word=%h expected 002", found, w);
        end
        ready[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = 9'($urandom_range(0, 127));
            exp_q.push_back(model_rx(2, d, -1, 0));
            send_frame(2, d, -1, 0, -1);
        end
        idle(2, 1);
        for (int k = 0; k < 3; k++) begin
            pop_word(2, found, w);
            checks++;
            if (!found || w !== exp_q[k]) begin
                errors++;
                $display("FAIL b2b_7o2_%0d got found=%0d word=%h expected %h", k, found, w, exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_8e1_parity();
        test_7o2_framing();
        test_glitch();
        test_overrun_break();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable-frame UART receiver: a parametrised successor to the fixed 8N1 receiver in the UART full-duplex datapath. It supports 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. Robustness features are a metastability synchroniser, 3-tap majority-vote sampling, break detection, and separate parity, framing and overrun errors. Received words go through a single-entry valid/ready holding register to the downstream consumer (FIFO or register bank).

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19200: line bit rate.
- OVERSAMPLE_RATE, 16: oversample ticks per bit; must be ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9; LSB first.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: flops in the input synchroniser; must be ≥ 2.
- Derived: TICK_CNT = CLK_FREQ/BAUD_RATE/OVERSAMPLE_RATE, which must be ≥ 2. MID = OVERSAMPLE_RATE/2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_serial_in  in  1  asynchronous serial line; idle high.
- rx_data_out  out  DATA_BITS  received word; held stable while rx_valid is high.
- rx_valid  out  1  rx_data_out and the error flags are valid.
- rx_ready  in  1  consumer accepts the word on a cycle with rx_valid && rx_ready.
- parity_err  out  1  sideband qualified by rx_valid; the word had a parity mismatch.
- frame_err  out  1  sideband qualified by rx_valid; a stop bit was sampled low.
- overrun_err  out  1  one-cycle pulse; a completed frame was dropped.
- break_det  out  1  one-cycle pulse; a break condition was detected.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- **Synchroniser.** rx_serial_in passes through SYNC_STAGES flops; all logic uses the synchronised output `rxs`.
- **Tick generator.** Counts 0..TICK_CNT-1 and produces a one-cycle `tick` at TICK_CNT-1. It is held at 0 in IDLE, so the first tick comes TICK_CNT cycles after start detection.
- **Vote shift register.** A 3-bit shift register captures `rxs` on each tick. `vote` is the majority of its 3 bits.
- **Sample counter.** `sample_cnt` runs 0..OVERSAMPLE_RATE-1 on ticks.
- **IDLE.**
  - On `rxs` == 0: clear the tick counter, sample_cnt and vote register, then go to START.
- **START.**
  - At the tick where sample_cnt == MID: if vote == 0, reset sample_cnt and go to DATA; otherwise (glitch) go to IDLE.
  - From here on, bit decisions fall at bit centres.
- **DATA.**
  - At the tick where sample_cnt == OVERSAMPLE_RATE-1, shift vote in at the MSB of a DATA_BITS shift register (LSB-first) and reset sample_cnt.
  - After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
- **PARITY.**
  - At the same decision point, capture the parity bit.
  - Expected value is the XOR of the data bits (even) or its inverse (odd).
  - A mismatch sets the pending parity error; then go to STOP.
- **STOP.**
  - Decide each of STOP_BITS bits at the same decision point; any vote == 0 sets the pending framing error.
  - At the last stop decision, the frame completes:
    - If the data bits, the parity bit (if present) and every stop bit were all 0, it is a break. Pulse break_det, deliver no word, go to BREAK.
    - Otherwise deliver the word (below) and go to IDLE immediately, i.e. mid stop bit. This allows a back-to-back start.
- **BREAK.**
  - Wait until vote == 1 at any tick, then go to IDLE.
- **Delivery.**
  - If rx_valid == 0, or rx_valid && rx_ready in the same cycle: load rx_data_out, parity_err and frame_err, and set rx_valid = 1.
  - Otherwise drop the frame; the held word and flags are unchanged and overrun_err pulses for 1 cycle.
  - Frames with frame_err or parity_err are still delivered.
- **Handshake.**
  - rx_valid clears on the cycle after rx_valid && rx_ready, unless a load happens in that same cycle.
  - rx_data_out and the flags do not change while rx_valid == 1 except through a load.
- **Reset.**
  - All outputs go to 0 (rx_data_out = 0); the state goes to IDLE.
  - The synchroniser resets to 1 (idle line); the counters and vote register reset to 0.
  - Reset mid-frame discards the partial frame. A line still low when reset releases is treated as a new start.

## Timing
- **Start detection.** The input edge reaches `rxs` after SYNC_STAGES cycles. The start is validated MID+1 ticks after detection.
- **Bit decisions.** Each subsequent decision is OVERSAMPLE_RATE ticks after the previous one.
- **Delivery latency.** rx_valid rises 1 clk after the tick of the last stop-bit decision. That is about (1 + DATA_BITS + parity + STOP_BITS − 0.5) bit times after the start edge.
- **Pulse outputs.** overrun_err and break_det are exactly 1 cycle wide, aligned with the would-be load cycle.
- **Consumer pacing.** rx_ready may be held high permanently; one word per frame then appears with no stalls.

## Test plan
- **8N1 (defaults).**
  - Stimulus: send 0xA5 with rx_ready = 1.
  - Required: rx_data_out = 0xA5 and rx_valid is high for 1 cycle. parity_err = frame_err = 0.
- **8E1 parity error.**
  - Stimulus: send 0x5A with parity bit 1 (correct is 0).
  - Required: rx_data_out = 0x5A, parity_err = 1. Then send 0x5B with parity 1 and require parity_err = 0.
- **7O2 framing error.**
  - Stimulus: send 0x3C with the second stop bit driven low.
  - Required: rx_data_out = 0x3C, frame_err = 1. Then send 0x41 with a correct frame and require both flags = 0.
- **Glitch and noise rejection.**
  - Stimulus: a 1-tick-wide low pulse in IDLE. Required: busy returns to 0 and no rx_valid.
  - Stimulus: a 1-tick inverted spike at the centre of data bit 3 of 0x00. Required: rx_data_out = 0x00 (vote rejects it).
- **Overrun then break.**
  - Stimulus: with rx_ready = 0, send 0x11 then 0x22. Required: rx_data_out stays 0x11 and overrun_err pulses once.
  - Stimulus: raise rx_ready. Required: rx_valid clears.
  - Stimulus: hold the line low for 12 bit times. Required: one break_det pulse and no rx_valid.
  - Stimulus: release the line, then send 0x7E. Required: 0x7E is delivered.
- **Reset mid-frame and back-to-back frames.**
  - Stimulus: assert rst during data bit 4. Required: all outputs = 0 and state IDLE.
  - Stimulus: send 0x01 and 0x02 with no idle gap. Required: both are delivered in order.
